// File: rtl/bf2i_pair_feeder.sv
// Input commutator for the BF2I radix-2 stage: buffers the first half-frame and pairs it with the second half.
// Optional macro FEEDER_FRAME_SYNC_EN adds a frame_start input that re-aligns framing to the tagged block.
module bf2i_pair_feeder #(
    parameter int WIDTH     = 15,
    parameter int DEPTH     = 8,
    parameter int HALF_BLKS = 4,
    localparam int CNT_W    = $clog2(2 * HALF_BLKS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     din_valid,
`ifdef FEEDER_FRAME_SYNC_EN
    input  logic                     frame_start,
`endif
    input  logic [WIDTH*DEPTH-1:0]   din_R,
    input  logic [WIDTH*DEPTH-1:0]   din_Q,
    output logic [WIDTH*DEPTH-1:0]   dout_R_1,
    output logic [WIDTH*DEPTH-1:0]   dout_R_2,
    output logic [WIDTH*DEPTH-1:0]   dout_Q_1,
    output logic [WIDTH*DEPTH-1:0]   dout_Q_2,
    output logic                     dout_valid,
    output logic                     dout_last,
    output logic [CNT_W-1:0]         blk_cnt
);

    // HALF_BLKS is expected to be a power of two so the low counter bits address the buffer.
    localparam int IDX_W = (HALF_BLKS > 1) ? $clog2(HALF_BLKS) : 1;
    localparam logic [CNT_W-1:0] FILL_END = CNT_W'(HALF_BLKS - 1);
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(2 * HALF_BLKS - 1);

    typedef enum logic {
        FILL,
        PAIR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt_next;
    logic                 sync_start;
    logic                 buf_we;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 pair_load;
    logic                 last_next;

    logic [WIDTH*DEPTH-1:0] buf_R [HALF_BLKS];
    logic [WIDTH*DEPTH-1:0] buf_Q [HALF_BLKS];

`ifdef FEEDER_FRAME_SYNC_EN
    assign sync_start = din_valid & frame_start;
`else
    assign sync_start = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= FILL;
            blk_cnt <= '0;
        end else begin
            state   <= state_next;
            blk_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = blk_cnt;
        if (sync_start) begin
            state_next = FILL;
            cnt_next   = CNT_W'(1);
        end else if (din_valid) begin
            unique case (state)
                FILL: begin
                    cnt_next = blk_cnt + 1'b1;
                    if (blk_cnt == FILL_END) state_next = PAIR;
                end
                PAIR: begin
                    if (blk_cnt == LAST_BLK) begin
                        cnt_next   = '0;
                        state_next = FILL;
                    end else begin
                        cnt_next = blk_cnt + 1'b1;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = FILL;
                end
            endcase
        end
    end

    // The entry read in PAIR is the one written HALF_BLKS blocks earlier, i.e. the same low bits.
    always_comb begin
        buf_we    = 1'b0;
        wr_idx    = blk_cnt[IDX_W-1:0];
        rd_idx    = blk_cnt[IDX_W-1:0];
        pair_load = 1'b0;
        last_next = 1'b0;
        if (sync_start) begin
            buf_we = 1'b1;
            wr_idx = '0;
        end else if (din_valid) begin
            if (state == FILL) begin
                buf_we = 1'b1;
            end else begin
                pair_load = 1'b1;
                last_next = (blk_cnt == LAST_BLK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_R[wr_idx] <= din_R;
            buf_Q[wr_idx] <= din_Q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_R_1   <= '0;
            dout_R_2   <= '0;
            dout_Q_1   <= '0;
            dout_Q_2   <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= pair_load;
            dout_last  <= last_next;
            if (pair_load) begin
                dout_R_1 <= buf_R[rd_idx];
                dout_Q_1 <= buf_Q[rd_idx];
                dout_R_2 <= din_R;
                dout_Q_2 <= din_Q;
            end
        end
    end

endmodule
